// File: rtl/game_state_pkg.sv
// Shared types and constants for the game-flow controller: state encodings and keycodes.
package game_state_pkg;

    localparam logic [2:0] OUT_MAIN_MENU  = 3'b000;
    localparam logic [2:0] OUT_LOADING    = 3'b001;
    localparam logic [2:0] OUT_GAME       = 3'b010;
    localparam logic [2:0] OUT_PAUSE      = 3'b011;
    localparam logic [2:0] OUT_REFRESHING = 3'b100;
    localparam logic [2:0] OUT_INIT       = 3'b101;
    localparam logic [2:0] OUT_GAME_OVER  = 3'b110;

    localparam logic [7:0] KEY_SPACE = 8'd44;
    localparam logic [7:0] KEY_ESC   = 8'd41;

    typedef enum logic [2:0] {
        ST_MAIN_MENU  = OUT_MAIN_MENU,
        ST_LOADING    = OUT_LOADING,
        ST_GAME       = OUT_GAME,
        ST_PAUSE      = OUT_PAUSE,
        ST_REFRESHING = OUT_REFRESHING,
        ST_INIT       = OUT_INIT,
        ST_GAME_OVER  = OUT_GAME_OVER
    } game_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame_clk into the Clock domain and emits a
// one-cycle pulse on each of its rising edges.
module frame_tick_sync (
    input  logic Clock,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic [1:0] sync_ff;
    logic       sync_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_ff   <= 2'b00;
            sync_prev <= 1'b0;
        end else begin
            sync_ff   <= {sync_ff[0], frame_clk};
            sync_prev <= sync_ff[1];
        end
    end

    assign frame_tick = sync_ff[1] & ~sync_prev;

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level game-flow controller: menu, loading, game, pause, refresh and
// game-over sequencing driven by key presses, frame ticks and game events.
module game_state_ctrl
    import game_state_pkg::*;
#(
    parameter int         LOAD_FRAMES      = 60,
    parameter int         OVER_HOLD_FRAMES = 30,
    parameter int         REFRESH_TIMEOUT  = 120,
    parameter logic [7:0] KEY_START        = KEY_SPACE,
    parameter logic [7:0] KEY_PAUSE        = KEY_ESC,
    localparam int        CNT_W            = $clog2(max3(LOAD_FRAMES, OVER_HOLD_FRAMES, REFRESH_TIMEOUT) + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic [7:0]       Keycode,
    input  logic             trigger,
    input  logic             monster_collision,
    input  logic             refresh_en,
    input  logic             game_over_trigger,
    output logic [2:0]       outstate,
    output logic             loadplat,
    output logic             state_entry,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam logic [CNT_W-1:0] LOAD_CNT    = CNT_W'(LOAD_FRAMES);
    localparam logic [CNT_W-1:0] HOLD_CNT    = CNT_W'(OVER_HOLD_FRAMES);
    localparam logic [CNT_W-1:0] REFRESH_CNT = CNT_W'(REFRESH_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    game_state_t      state;
    game_state_t      next_state;
    logic [7:0]       prev_key;
    logic [CNT_W-1:0] cnt_next;
    logic             frame_tick;
    logic             start_hit;
    logic             pause_hit;
    logic             any_hit;
    logic             counting;
    logic             refresh_expired;
    logic             hold_done;

    frame_tick_sync u_frame_tick_sync (
        .Clock      (Clock),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (frame_tick)
    );

    // A key fires only on the cycle its code first appears, so holding a key never repeats.
    assign start_hit = (Keycode == KEY_START) && (Keycode != 8'd0) && (prev_key != KEY_START);
    assign pause_hit = (Keycode == KEY_PAUSE) && (Keycode != 8'd0) && (prev_key != KEY_PAUSE);
    assign any_hit   = (Keycode != 8'd0) && (Keycode != prev_key);

    assign counting        = (state == ST_LOADING) || (state == ST_GAME_OVER) || (state == ST_REFRESHING);
    assign refresh_expired = (REFRESH_TIMEOUT != 0) && (frame_cnt == REFRESH_CNT);
    assign hold_done       = (frame_cnt >= HOLD_CNT);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT:       next_state = ST_MAIN_MENU;
            ST_MAIN_MENU:  if (start_hit) next_state = ST_LOADING;
            ST_LOADING:    if (frame_cnt == LOAD_CNT) next_state = ST_GAME;
            ST_GAME: begin
                if (pause_hit)                                   next_state = ST_PAUSE;
                else if (game_over_trigger || monster_collision) next_state = ST_GAME_OVER;
                else if (refresh_en)                             next_state = ST_REFRESHING;
            end
            ST_PAUSE:      if (any_hit) next_state = ST_GAME;
            ST_REFRESHING: if (trigger || refresh_expired) next_state = ST_GAME;
            ST_GAME_OVER:  if (pause_hit && hold_done) next_state = ST_INIT;
            default:       next_state = ST_INIT;
        endcase
    end

    always_comb begin
        cnt_next = frame_cnt;
        if ((next_state != state) || !counting) begin
            cnt_next = '0;
        end else if (frame_tick && (frame_cnt != CNT_MAX)) begin
            cnt_next = frame_cnt + 1'b1;
        end
    end

    // NOTE: Reset is synchronous; it is just the highest-priority branch inside the clocked block.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= ST_INIT;
            outstate    <= OUT_INIT;
            loadplat    <= 1'b0;
            state_entry <= 1'b0;
            frame_cnt   <= '0;
            prev_key    <= 8'd0;
        end else begin
            state       <= next_state;
            outstate    <= next_state;
            loadplat    <= (next_state == ST_LOADING);
            state_entry <= (next_state != state);
            frame_cnt   <= cnt_next;
            prev_key    <= Keycode;
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scenario bench for game_state_ctrl: each state entry is predicted into a
// scoreboard queue and matched against entries seen by a monitor.
module tb_game_state_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       lp;
    } entry_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [7:0] Keycode = 8'd0;
    logic       trigger = 1'b0;
    logic       monster_collision = 1'b0;
    logic       refresh_en = 1'b0;
    logic       game_over_trigger = 1'b0;
    logic [2:0] outstate;
    logic       loadplat;
    logic       state_entry;
    logic [2:0] frame_cnt;

    entry_t exp_q[$];
    entry_t obs_q[$];
    int     total = 0;
    int     bad = 0;

    game_state_ctrl #(
        .LOAD_FRAMES      (4),
        .OVER_HOLD_FRAMES (2),
        .REFRESH_TIMEOUT  (3)
    ) dut (
        .Clock             (Clock),
        .Reset             (Reset),
        .frame_clk         (frame_clk),
        .Keycode           (Keycode),
        .trigger           (trigger),
        .monster_collision (monster_collision),
        .refresh_en        (refresh_en),
        .game_over_trigger (game_over_trigger),
        .outstate          (outstate),
        .loadplat          (loadplat),
        .state_entry       (state_entry),
        .frame_cnt         (frame_cnt)
    );

    always #5 Clock = ~Clock;

    // Monitor: record every state entry, sampled on the falling edge.
    always @(negedge Clock) begin
        if (state_entry === 1'b1) obs_q.push_back({outstate, loadplat});
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // One full frame_clk period of 8 Clock cycles; yields exactly one frame tick.
    task automatic frame_pulse();
        frame_clk = 1'b1;
        repeat (4) step();
        frame_clk = 1'b0;
        repeat (4) step();
    endtask

    task automatic push_exp(input logic [2:0] st, input logic lp);
        exp_q.push_back({st, lp});
    endtask

    task automatic test_reset();
        entry_t e, o;
        Reset = 1'b1;
        repeat (3) step();
        total++;
        if ({outstate, loadplat, state_entry, frame_cnt} !== {3'b101, 1'b0, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL reset_state: got st=%b lp=%b se=%b cnt=%0d want st=101 lp=0 se=0 cnt=0",
                     outstate, loadplat, state_entry, frame_cnt);
        end
        push_exp(3'b000, 1'b0);
        Reset = 1'b0;
        total++;
        if (outstate !== 3'b101) begin
            bad++;
            $display("FAIL init_hold: got st=%b want 101", outstate);
        end
        step();
        total++;
        if ({outstate, state_entry} !== {3'b000, 1'b1}) begin
            bad++;
            $display("FAIL menu_entry: got st=%b se=%b want st=000 se=1", outstate, state_entry);
        end
        step();
        step();
        total++;
        if ({outstate, state_entry, loadplat} !== {3'b000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL menu_idle: got st=%b se=%b lp=%b want st=000 se=0 lp=0", outstate, state_entry, loadplat);
        end
        step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL reset_sb: got no entry want st=%b lp=%b", e.st, e.lp);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL reset_sb: got st=%b lp=%b want st=%b lp=%b", o.st, o.lp, e.st, e.lp);
                end
            end
        end
    endtask

    task automatic test_ignore_outside_game();
        monster_collision = 1'b1;
        game_over_trigger = 1'b1;
        refresh_en        = 1'b1;
        trigger           = 1'b1;
        repeat (3) step();
        total++;
        if (outstate !== 3'b000) begin
            bad++;
            $display("FAIL ignore_menu: got st=%b want 000", outstate);
        end
        monster_collision = 1'b0;
        game_over_trigger = 1'b0;
        refresh_en        = 1'b0;
        trigger           = 1'b0;
        step();
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL ignore_sb: got %0d entries want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_loading();
        entry_t e, o;
        push_exp(3'b001, 1'b1);
        Keycode = 8'd44;
        step();
        total++;
        if ({outstate, loadplat, frame_cnt} !== {3'b001, 1'b1, 3'd0}) begin
            bad++;
            $display("FAIL load_entry: got st=%b lp=%b cnt=%0d want st=001 lp=1 cnt=0", outstate, loadplat, frame_cnt);
        end
        repeat (3) frame_pulse();
        total++;
        if ({outstate, loadplat, frame_cnt} !== {3'b001, 1'b1, 3'd3}) begin
            bad++;
            $display("FAIL load_dwell: got st=%b lp=%b cnt=%0d want st=001 lp=1 cnt=3", outstate, loadplat, frame_cnt);
        end
        push_exp(3'b010, 1'b0);
        frame_pulse();
        total++;
        if ({outstate, loadplat, frame_cnt} !== {3'b010, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL load_done: got st=%b lp=%b cnt=%0d want st=010 lp=0 cnt=0", outstate, loadplat, frame_cnt);
        end
        Keycode = 8'd0;
        step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL load_sb: got no entry want st=%b lp=%b", e.st, e.lp);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL load_sb: got st=%b lp=%b want st=%b lp=%b", o.st, o.lp, e.st, e.lp);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL load_extra: got %0d entries want 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_pause();
        entry_t e, o;
        push_exp(3'b011, 1'b0);
        game_over_trigger = 1'b1;
        Keycode           = 8'd41;
        step();
        game_over_trigger = 1'b0;
        total++;
        if (outstate !== 3'b011) begin
            bad++;
            $display("FAIL pause_priority: got st=%b want 011", outstate);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (outstate !== 3'b011) begin
                bad++;
                $display("FAIL pause_held_%0d: got st=%b want 011", i, outstate);
            end
        end
        Keycode = 8'd0;
        step();
        total++;
        if (outstate !== 3'b011) begin
            bad++;
            $display("FAIL pause_release: got st=%b want 011", outstate);
        end
        push_exp(3'b010, 1'b0);
        Keycode = 8'd4;
        step();
        total++;
        if (outstate !== 3'b010) begin
            bad++;
            $display("FAIL pause_resume: got st=%b want 010", outstate);
        end
        Keycode = 8'd0;
        step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL pause_sb: got no entry want st=%b lp=%b", e.st, e.lp);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL pause_sb: got st=%b lp=%b want st=%b lp=%b", o.st, o.lp, e.st, e.lp);
                end
            end
        end
    endtask

    task automatic test_refresh();
        entry_t e, o;
        push_exp(3'b100, 1'b0);
        refresh_en = 1'b1;
        step();
        refresh_en = 1'b0;
        total++;
        if (outstate !== 3'b100) begin
            bad++;
            $display("FAIL refresh_entry: got st=%b want 100", outstate);
        end
        repeat (2) frame_pulse();
        total++;
        if ({outstate, frame_cnt} !== {3'b100, 3'd2}) begin
            bad++;
            $display("FAIL refresh_wait: got st=%b cnt=%0d want st=100 cnt=2", outstate, frame_cnt);
        end
        push_exp(3'b010, 1'b0);
        frame_pulse();
        total++;
        if ({outstate, frame_cnt} !== {3'b010, 3'd0}) begin
            bad++;
            $display("FAIL refresh_timeout: got st=%b cnt=%0d want st=010 cnt=0", outstate, frame_cnt);
        end
        push_exp(3'b100, 1'b0);
        refresh_en = 1'b1;
        step();
        refresh_en = 1'b0;
        frame_pulse();
        total++;
        if ({outstate, frame_cnt} !== {3'b100, 3'd1}) begin
            bad++;
            $display("FAIL refresh_second: got st=%b cnt=%0d want st=100 cnt=1", outstate, frame_cnt);
        end
        push_exp(3'b010, 1'b0);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        total++;
        if (outstate !== 3'b010) begin
            bad++;
            $display("FAIL refresh_trigger: got st=%b want 010", outstate);
        end
        step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL refresh_sb: got no entry want st=%b lp=%b", e.st, e.lp);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL refresh_sb: got st=%b lp=%b want st=%b lp=%b", o.st, o.lp, e.st, e.lp);
                end
            end
        end
    endtask

    task automatic test_game_over();
        entry_t e, o;
        push_exp(3'b110, 1'b0);
        monster_collision = 1'b1;
        step();
        monster_collision = 1'b0;
        total++;
        if ({outstate, frame_cnt} !== {3'b110, 3'd0}) begin
            bad++;
            $display("FAIL over_entry: got st=%b cnt=%0d want st=110 cnt=0", outstate, frame_cnt);
        end
        frame_pulse();
        Keycode = 8'd41;
        step();
        total++;
        if ({outstate, frame_cnt} !== {3'b110, 3'd1}) begin
            bad++;
            $display("FAIL over_early_key: got st=%b cnt=%0d want st=110 cnt=1", outstate, frame_cnt);
        end
        frame_pulse();
        total++;
        if ({outstate, frame_cnt} !== {3'b110, 3'd2}) begin
            bad++;
            $display("FAIL over_not_queued: got st=%b cnt=%0d want st=110 cnt=2", outstate, frame_cnt);
        end
        Keycode = 8'd0;
        step();
        push_exp(3'b101, 1'b0);
        push_exp(3'b000, 1'b0);
        Keycode = 8'd41;
        step();
        total++;
        if ({outstate, loadplat} !== {3'b101, 1'b0}) begin
            bad++;
            $display("FAIL over_restart: got st=%b lp=%b want st=101 lp=0", outstate, loadplat);
        end
        step();
        total++;
        if (outstate !== 3'b000) begin
            bad++;
            $display("FAIL over_to_menu: got st=%b want 000", outstate);
        end
        Keycode = 8'd0;
        step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL over_sb: got no entry want st=%b lp=%b", e.st, e.lp);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL over_sb: got st=%b lp=%b want st=%b lp=%b", o.st, o.lp, e.st, e.lp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_loading();
        entry_t e, o;
        push_exp(3'b001, 1'b1);
        Keycode = 8'd44;
        step();
        Keycode = 8'd0;
        repeat (2) frame_pulse();
        total++;
        if ({outstate, frame_cnt} !== {3'b001, 3'd2}) begin
            bad++;
            $display("FAIL midload_cnt: got st=%b cnt=%0d want st=001 cnt=2", outstate, frame_cnt);
        end
        Reset = 1'b1;
        step();
        total++;
        if ({outstate, frame_cnt, loadplat} !== {3'b101, 3'd0, 1'b0}) begin
            bad++;
            $display("FAIL midload_reset: got st=%b cnt=%0d lp=%b want st=101 cnt=0 lp=0", outstate, frame_cnt, loadplat);
        end
        push_exp(3'b000, 1'b0);
        Reset = 1'b0;
        step();
        total++;
        if (outstate !== 3'b000) begin
            bad++;
            $display("FAIL midload_menu: got st=%b want 000", outstate);
        end
        step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (obs_q.size() == 0) begin
                bad++;
                $display("FAIL midload_sb: got no entry want st=%b lp=%b", e.st, e.lp);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    bad++;
                    $display("FAIL midload_sb: got st=%b lp=%b want st=%b lp=%b", o.st, o.lp, e.st, e.lp);
                end
            end
        end
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL final_extra: got %0d entries want 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_ignore_outside_game();
        test_loading();
        test_pause();
        test_refresh();
        test_game_over();
        test_reset_mid_loading();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Top-level game-flow controller; parametrised successor of the fixed-delay jump state machine.
- Sequences INIT -> main menu -> loading -> game, plus pause, platform refresh and game-over.
- Adds edge-detected key presses, frame-tick synchronisation, parametrised load/hold/timeout durations, refresh timeout and a one-cycle state-entry pulse.
- Sits between the keyboard/collision logic and the platform/sprite/draw blocks. Everything is clocked on Clock; frame_clk is only sampled.

Parameters:
- LOAD_FRAMES, 60, frame ticks spent in LOADING before GAME (1..1023).
- OVER_HOLD_FRAMES, 30, frame ticks in GAME_OVER before the restart key is accepted (0 = accept immediately).
- REFRESH_TIMEOUT, 120, frame ticks in REFRESHING without trigger before forced return to GAME (0 = no timeout).
- KEY_START, 8'd44, keycode that starts the game (space).
- KEY_PAUSE, 8'd41, keycode for pause and restart (esc).

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high
- frame_clk  in  1  vertical-sync-rate clock, asynchronous to Clock
- Keycode  in  8  current USB keycode; 0 = no key
- trigger  in  1  platform refresh done
- monster_collision  in  1  level, sampled in GAME
- refresh_en  in  1  level, request platform refresh
- game_over_trigger  in  1  level, player fell
- outstate  out  3  encoded state
- loadplat  out  1  high only in LOADING
- state_entry  out  1  one-cycle pulse on the first cycle of every new state
- frame_cnt  out  CNT_W  frames elapsed in the current timed state

Behaviour:
- Reset: state INIT, outstate 3'b101, loadplat 0, state_entry 0, frame_cnt 0, key history 0.
- Reset wins over every other input at any time, including mid-LOADING; the counter clears.
- State encodings for outstate: INIT 101, MAIN_MENU 000, LOADING 001, GAME 010, PAUSE 011, REFRESHING 100, GAME_OVER 110.
- outstate and loadplat are registered and change in the same cycle as the state register.
- Frame tick: frame_clk passes through a 2-FF synchroniser, then rising-edge detection gives frame_tick, one Clock cycle wide.
- Key press: key_hit(k) is true for exactly one cycle, when Keycode == k, Keycode != 0 and the previous Keycode != k. A held key never re-fires.
- any_hit is the same test with "any non-zero new code".
- Counter:
  - CNT_W = $clog2(max(LOAD_FRAMES, OVER_HOLD_FRAMES, REFRESH_TIMEOUT) + 1).
  - Clears to 0 on every state change.
  - Increments on frame_tick in LOADING, GAME_OVER and REFRESHING; saturates at 2^CNT_W - 1.
  - Holds 0 in all other states.
- Transitions (evaluated each Clock cycle):
  - INIT -> MAIN_MENU unconditionally, after 1 cycle.
  - MAIN_MENU -> LOADING on key_hit(KEY_START).
  - LOADING -> GAME when frame_cnt == LOAD_FRAMES, so dwell is LOAD_FRAMES ticks plus less than one frame.
  - GAME priority:
    1. key_hit(KEY_PAUSE) -> PAUSE
    2. game_over_trigger -> GAME_OVER
    3. monster_collision -> GAME_OVER
    4. refresh_en -> REFRESHING
    5. otherwise stay
  - PAUSE -> GAME on any_hit. The pausing esc is still held, so it does not resume; a release followed by a new press is required.
  - REFRESHING -> GAME on trigger. Also -> GAME when REFRESH_TIMEOUT != 0 and frame_cnt == REFRESH_TIMEOUT. trigger and timeout in the same cycle give the same result.
  - GAME_OVER -> INIT on key_hit(KEY_PAUSE), only if frame_cnt >= OVER_HOLD_FRAMES. A press arriving earlier is discarded, not queued.
- state_entry is registered as (next_state != state); it is high in the first cycle the new state is visible.
- Collision and fall inputs are ignored outside GAME.

Decomposition:
- game_state_pkg:
  - state enum typedef game_state_t (logic [2:0], encodings above)
  - OUT_* encoding constants
  - KEY_SPACE = 8'd44, KEY_ESC = 8'd41
- Sub-module frame_tick_sync: 2-FF synchroniser plus rising-edge pulse. Ports Clock, Reset, frame_clk, frame_tick.

Test Plan:
- Reset, then idle 3 cycles -> outstate 101 for 1 cycle, then 000; state_entry pulses on the 000 entry; loadplat 0.
- LOAD_FRAMES=4, press space in MAIN_MENU -> LOADING (001, loadplat 1) for exactly 4 frame ticks, then 010; holding space does not retrigger.
- In GAME:
  - Assert game_over_trigger and esc press in the same cycle -> 011 (pause wins).
  - Keep esc held 10 cycles -> stays 011.
  - Release, then press 8'd4 -> 010.
- REFRESH_TIMEOUT=3:
  - refresh_en in GAME -> 100; no trigger -> back to 010 after 3 ticks.
  - Repeat with trigger after 1 tick -> 010 the next cycle.
- OVER_HOLD_FRAMES=2:
  - monster_collision -> 110.
  - esc press at frame_cnt 1 is ignored.
  - Release and re-press at frame_cnt 2 -> 101, then 000.
- Assert Reset mid-LOADING at frame_cnt 2 -> next cycle outstate 101, frame_cnt 0, loadplat 0.
